div_arbiter: RTL and testbench

Sequencer and two-port round-robin arbiter for the shared 32-bit unsigned divider datapath. It accepts divide requests from two independent requesters and latches each granted request's operands. It drives the divider's load, run and reset controls, waits for divider ready, and returns quotient and remainder to the owning requester with a one-cycle acknowledge. It also screens divide-by-zero and guards against a hung divider with a timeout.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_arbiter_rr_arb2.sv | 13 +
 rtl/div_arbiter.sv | 122 ++++++++++++
 tb/tb_div_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divider sequencer
package div_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_TIMEOUT = 40;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    // divide-by-zero result: all-ones quotient, remainder echoes the dividend
    localparam logic [DEF_WIDTH-1:0] DZ_Q   = '1;
    localparam logic                 DZ_ERR = 1'b1;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; sel = 1 picks B, prio breaks ties
module rr_arb2 (
    input  logic req_a,
    input  logic req_b,
    input  logic prio,
    output logic gnt,
    output logic sel
);

    assign gnt = req_a | req_b;
    assign sel = req_b & (~req_a | prio);

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: two-port round-robin sequencer for the shared divider
module div_arbiter
    import div_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] dvnd_a,
    input  logic [WIDTH-1:0] dvnd_b,
    input  logic [WIDTH-1:0] dvsr_a,
    input  logic [WIDTH-1:0] dvsr_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic [WIDTH-1:0] q_a,
    output logic [WIDTH-1:0] q_b,
    output logic [WIDTH-1:0] r_a,
    output logic [WIDTH-1:0] r_b,
    output logic             err_a,
    output logic             err_b,
    output logic [WIDTH-1:0] div_dvnd,
    output logic [WIDTH-1:0] div_dvsr,
    output logic             div_rst,
    output logic             div_run,
    input  logic             div_rdy,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t           state, state_nx;
    logic             prio, owner, gnt, sel, dz, tmo;
    logic             res_we, res_own, res_e;
    logic [WIDTH-1:0] dvnd_l, dvsr_l, dvnd_g, dvsr_g, res_q, res_r;
    logic [CW-1:0]    cnt;

    rr_arb2 u_arb (
        .req_a(req_a),
        .req_b(req_b),
        .prio (prio),
        .gnt  (gnt),
        .sel  (sel)
    );

    assign dvnd_g = sel ? dvnd_b : dvnd_a;
    assign dvsr_g = sel ? dvsr_b : dvsr_a;
    assign dz     = dvsr_g == '0;
    assign tmo    = cnt == CW'(TIMEOUT - 1);

    // result write-back: divide-by-zero at grant, or divider finish/timeout in RUN
    always_comb begin
        res_we  = (state == IDLE && gnt && dz) || (state == RUN && (div_rdy || tmo));
        res_own = state == IDLE ? sel : owner;
        res_q   = state == IDLE ? '1 : div_rdy ? div_q : '0;
        res_r   = state == IDLE ? dvnd_g : div_rdy ? div_r : '0;
        res_e   = state == IDLE ? DZ_ERR : ~div_rdy;
    end

    // next-state sequencing; a ready divider wins over a same-cycle timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (gnt) state_nx = dz ? DONE : LOAD;
            LOAD:    state_nx = RUN;
            RUN:     if (div_rdy || tmo) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end

    // operand latch, run counter, per-port results and priority pointer
    always_ff @(posedge clk) begin
        if (Rst) begin
            prio   <= 1'b0;
            owner  <= 1'b0;
            dvnd_l <= '0;
            dvsr_l <= '0;
            cnt    <= '0;
            q_a    <= '0;
            r_a    <= '0;
            err_a  <= 1'b0;
            q_b    <= '0;
            r_b    <= '0;
            err_b  <= 1'b0;
        end else begin
            if (state == IDLE && gnt) begin
                owner  <= sel;
                dvnd_l <= dvnd_g;
                dvsr_l <= dvsr_g;
            end
            cnt <= state == RUN ? cnt + 1'b1 : '0;
            if (res_we && !res_own) begin
                q_a   <= res_q;
                r_a   <= res_r;
                err_a <= res_e;
            end
            if (res_we && res_own) begin
                q_b   <= res_q;
                r_b   <= res_r;
                err_b <= res_e;
            end
            if (state == DONE) prio <= ~owner;
        end
    end

    assign ack_a    = state == DONE && !owner;
    assign ack_b    = state == DONE && owner;
    assign div_rst  = Rst || state == LOAD;
    assign div_run  = state == RUN;
    assign div_dvnd = dvnd_l;
    assign div_dvsr = dvsr_l;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: randomized scoreboard bench with a behavioural divider and arbiter model
module tb_div_arbiter;

    localparam int TO = 40;

    logic        clk = 1'b0, Rst = 1'b1, req_a = 1'b0, req_b = 1'b0;
    logic [31:0] dvnd_a = '0, dvnd_b = '0, dvsr_a = '0, dvsr_b = '0;
    logic        ack_a, ack_b, err_a, err_b, div_rst, div_run, div_rdy;
    logic [31:0] q_a, q_b, r_a, r_b, div_dvnd, div_dvsr, div_q, div_r;

    div_arbiter dut (
        .clk(clk), .Rst(Rst), .req_a(req_a), .req_b(req_b),
        .dvnd_a(dvnd_a), .dvnd_b(dvnd_b), .dvsr_a(dvsr_a), .dvsr_b(dvsr_b),
        .ack_a(ack_a), .ack_b(ack_b), .q_a(q_a), .q_b(q_b), .r_a(r_a), .r_b(r_b),
        .err_a(err_a), .err_b(err_b), .div_dvnd(div_dvnd), .div_dvsr(div_dvsr),
        .div_rst(div_rst), .div_run(div_run), .div_rdy(div_rdy),
        .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // divider model: ready in RUN cycle 'lat' (0 = never), results valid only while ready
    int lat = 1;
    int rc = 0;
    always @(posedge clk) begin
        if (div_rst) rc <= 0;
        else if (div_run) rc <= rc + 1;
    end
    assign div_rdy = div_run && lat > 0 && rc == lat - 1;
    assign div_q = div_rdy ? (div_dvsr != 0 ? div_dvnd / div_dvsr : 32'h0) : 32'hDEADBEEF;
    assign div_r = div_rdy ? (div_dvsr != 0 ? div_dvnd % div_dvsr : 32'h0) : 32'hBADC0FFE;

    typedef struct {
        bit          port;
        logic [31:0] q;
        logic [31:0] r;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] mq[2];
    logic [31:0] mr[2];
    logic        me[2];
    bit          mprio = 1'b0;
    int          nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input bit p, input logic [31:0] d, input logic [31:0] s,
                                input int k, input int t);
        exp_t e;
        e.port = p;
        if (s == 0) begin
            e.q = 32'hFFFFFFFF; e.r = d; e.err = 1'b1; e.cyc = t + 1;
        end else if (k == 0 || k > TO) begin
            e.q = 32'h0; e.r = 32'h0; e.err = 1'b1; e.cyc = t + 2 + TO;
        end else begin
            e.q = d / s; e.r = d % s; e.err = 1'b0; e.cyc = t + 2 + k;
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = '0; mr[i] = '0; me[i] = 1'b0;
        end
        mprio = 1'b0;
        sbq.delete();
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_q_a"}, q_a, mq[0]);
        chk({tag, "_r_a"}, r_a, mr[0]);
        chk({tag, "_err_a"}, 32'(err_a), 32'(me[0]));
        chk({tag, "_q_b"}, q_b, mq[1]);
        chk({tag, "_r_b"}, r_b, mr[1]);
        chk({tag, "_err_b"}, 32'(err_b), 32'(me[1]));
    endtask

    // monitor: every ack pops the scoreboard and checks owner, timing and both ports' results
    always @(negedge clk) begin
        if (!Rst && (ack_a || ack_b)) begin
            exp_t e;
            chk("ack_exclusive", 32'(ack_a & ack_b), 32'h0);
            if (sbq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_ack: got ack_a=%b ack_b=%b expected none (cycle %0d)", ack_a, ack_b, cyc);
            end else begin
                e = sbq.pop_front();
                chk("ack_port", 32'(ack_b), 32'(e.port));
                chk("ack_cycle", 32'(cyc), 32'(e.cyc));
                mq[e.port] = e.q;
                mr[e.port] = e.r;
                me[e.port] = e.err;
            end
            chk_outputs("ack");
        end
    end

    // one request episode: A, B or both; hold keeps a lone A request up through its first ack
    task automatic txn(input bit ea, input bit eb, input bit hold,
                       input logic [31:0] da, input logic [31:0] sa,
                       input logic [31:0] db, input logic [31:0] sb, input int k);
        exp_t e1, e2;
        bit   first, second;
        int   n, got, budget;
        @(negedge clk);
        lat = k;
        if (ea) begin req_a = 1'b1; dvnd_a = da; dvsr_a = sa; end
        if (eb) begin req_b = 1'b1; dvnd_b = db; dvsr_b = sb; end
        first  = (ea && eb) ? mprio : eb;
        e1     = mk(first, first ? db : da, first ? sb : sa, k, cyc);
        sbq.push_back(e1);
        n      = 1;
        second = first;
        if ((ea && eb) || hold) begin
            second = (ea && eb) ? !first : first;
            e2     = mk(second, second ? db : da, second ? sb : sa, k, e1.cyc + 1);
            sbq.push_back(e2);
            n = 2;
        end
        got    = 0;
        budget = 0;
        while (got < n && budget < 300) begin
            @(negedge clk);
            budget++;
            if (ack_a || ack_b) begin
                got++;
                if (ack_a && !(hold && got == 1)) begin
                    req_a = 1'b0; dvnd_a = $urandom; dvsr_a = $urandom;
                end
                if (ack_b) begin
                    req_b = 1'b0; dvnd_b = $urandom; dvsr_b = $urandom;
                end
            end
        end
        if (got < n) begin
            nvec++;
            nerr++;
            $display("FAIL ack_wait: got %0d acks expected %0d", got, n);
            req_a = 1'b0;
            req_b = 1'b0;
        end
        mprio = !second;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] sa, sb;
        int          k;
        bit          ea, eb;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_div_rst", 32'(div_rst), 32'h1);
        chk("rst_div_run", 32'(div_run), 32'h0);
        chk("rst_ack", 32'({ack_a, ack_b}), 32'h0);
        chk_outputs("rst");
        Rst = 1'b0;

        txn(1, 1, 0, 32'd50, 32'd5, 32'd9, 32'd4, 12);
        txn(1, 0, 0, 32'd100, 32'd7, 0, 0, 33);
        txn(0, 1, 0, 0, 0, 32'h1234, 32'h0, 10);
        txn(1, 0, 0, 32'd77, 32'd3, 0, 0, 0);
        txn(0, 1, 0, 0, 0, 32'd1000, 32'd9, 5);
        txn(1, 0, 0, 32'd12345, 32'd11, 0, 0, 1);
        txn(0, 1, 0, 0, 0, 32'hFFFF0000, 32'd3, TO);
        txn(1, 1, 0, 32'd81, 32'd9, 32'd64, 32'd8, TO + 1);
        txn(1, 0, 1, 32'd999, 32'd10, 0, 0, 7);
        txn(1, 1, 0, 32'd7, 32'd0, 32'd30, 32'd7, 3);

        @(negedge clk);
        lat   = 20;
        req_a = 1'b1;
        dvnd_a = 32'd500;
        dvsr_a = 32'd6;
        repeat (6) @(negedge clk);
        chk("midrun_div_run", 32'(div_run), 32'h1);
        Rst   = 1'b1;
        req_a = 1'b0;
        #1;
        chk("midrun_div_rst", 32'(div_rst), 32'h1);
        @(negedge clk);
        Rst = 1'b0;
        model_reset();
        #1;
        chk("post_rst_div_rst", 32'(div_rst), 32'h0);
        chk("post_rst_div_run", 32'(div_run), 32'h0);
        chk("post_rst_ack", 32'({ack_a, ack_b}), 32'h0);
        chk_outputs("post_rst");
        repeat (25) @(negedge clk);
        txn(1, 0, 0, 32'hFFFFFFFF, 32'd1, 0, 0, 33);

        for (int i = 0; i < 40; i++) begin
            ea = $urandom_range(0, 1) == 1;
            eb = !ea || $urandom_range(0, 1) == 1;
            sa = $urandom_range(0, 7) == 0 ? 32'h0 : $urandom >> $urandom_range(0, 31);
            sb = $urandom_range(0, 7) == 0 ? 32'h0 : $urandom >> $urandom_range(0, 31);
            k  = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, TO + 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            txn(ea, eb, ea && !eb && $urandom_range(0, 3) == 0, $urandom, sa, $urandom, sb, k);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
